// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted
// and sign/zero-extended. Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN
// turns misaligned requests into an immediate error response with no
// memory traffic. Handshake: a request transfers on a rising edge where
// req_valid and req_ready are both high; req_ready is high only in IDLE.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [15:0]           wdata_q;
    logic [DATA_WIDTH-1:0] rbuf_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  accept;
    logic                  trap;
    logic                  err_w;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign accept = (state_q == IDLE) && req_valid;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic err_q;
    assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                  (req_size == 2'b11);
    assign err_w = err_q;

    // Error flag for the current request, latched at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (accept) err_q <= trap;
    end
`else
    assign trap  = 1'b0;
    assign err_w = 1'b0;
`endif

    // Replace the addressed byte or halfword lanes of a read word
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] word,
        input logic [15:0]           data,
        input logic [1:0]            size,
        input logic [1:0]            off
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        if (size == 2'b00) r[{off, 3'b000} +: 8] = data[7:0];
        else               r[{off[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: word stores skip the read, sub-word stores read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (trap)                      state_d = RESP;
                    else if (req_we && req_size[1]) state_d = WR;
                    else                           state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read buffer and memory-side address/data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q       <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept) begin
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            if (!trap) begin
                mem_addr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                if (req_we && req_size[1]) mem_wdata_q <= req_wdata;
            end
        end else if (state_q == RD) begin
            rbuf_q <= mem_rdata;
            if (we_q) mem_wdata_q <= merge_lanes(mem_rdata, wdata_q, size_q, off_q);
        end
    end

    // Lane extraction and extension of the buffered word for loads
    always_comb begin
        lane_byte = rbuf_q[{off_q, 3'b000} +: 8];
        lane_half = rbuf_q[{off_q[1], 4'b0000} +: 16];
        load_data = rbuf_q;
        case (size_q)
            2'b00: load_data = uns_q ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                                     : {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
            2'b01: load_data = uns_q ? {{(DATA_WIDTH-16){1'b0}}, lane_half}
                                     : {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
            default: load_data = rbuf_q;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_w;
    assign resp_rdata = ((state_q == RESP) && !we_q && !err_w) ? load_data : '0;
    assign mem_we     = (state_q == WR);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
